saa_capture_sram_writer: RTL

- Upstream neighbour of the ADV7179 output stage; shares the same field-interleaved SRAM frame store.
- Parses the 8-bit BT.656 stream from the SAA711x decoder (27 MHz byte rate) and packs each Cb/Cr+Y byte pair into one 16-bit word, {Y[15:8], C[7:0]}.
- Writes each word at field*FIELD_STRIDE + line*LINE_WORDS + pixel_word, the layout the output stage reads back.
- Writes only active video; blanking and ancillary data are discarded.

---
 rtl/saa_capture_pkg.sv | 28 ++
 rtl/bt656_timing_decoder.sv | 32 +++
 rtl/saa_capture_sram_writer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/saa_capture_pkg.sv
// Shared types and constants for the SAA711x BT.656 capture path into the field-interleaved SRAM.
// The frame-store layout constants must match what the ADV7179 output stage reads back.
package saa_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FF,
    ESC1,
    ESC2,
    XY,
    ACTIVE,
    ERROR
  } cap_state_e;

  localparam logic [19:0] FIELD_STRIDE = 20'h32A00;
  localparam int          LINE_WORDS   = 720;
  localparam int          MAX_LINES    = 288;
  localparam int          LINE_BYTES   = 2 * LINE_WORDS;

  localparam logic [7:0]  BT_CODE_FF   = 8'hFF;
  localparam logic [7:0]  BT_CODE_00   = 8'h00;

  // Expected P3..P0 of an XY byte for the given F/V/H flags.
  function automatic logic [3:0] bt656_prot(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/bt656_timing_decoder.sv
// Combinational BT.656 byte classifier: escape bytes, XY flags and, when SAV_PROT_CHECK_EN
// is defined, the P3..P0 protection check on the XY byte.
module bt656_timing_decoder
  import saa_capture_pkg::*;
(
  input  logic [7:0] qd,
  output logic       is_ff,
  output logic       is_zero,
  output logic       f,
  output logic       v,
  output logic       h,
  output logic       prot_err
);

  assign is_ff   = (qd == BT_CODE_FF);
  assign is_zero = (qd == BT_CODE_00);
  assign f       = qd[6];
  assign v       = qd[5];
  assign h       = qd[4];

`ifdef SAV_PROT_CHECK_EN
  logic unused_bits;
  assign prot_err    = (qd[3:0] != bt656_prot(qd[6], qd[5], qd[4]));
  assign unused_bits = qd[7];
`else
  // Protection bits are not trusted here; only F/V/H steer the capture FSM.
  logic unused_bits;
  assign prot_err    = 1'b0;
  assign unused_bits = ^{qd[7], qd[3:0]};
`endif

endmodule

// File: rtl/saa_capture_sram_writer.sv
// BT.656 capture FSM and packer: writes active video as {Y,C} words into the field-interleaved
// SRAM frame store. Optional XY protection check selected by macro SAV_PROT_CHECK_EN.
module saa_capture_sram_writer
  import saa_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  qd_in,
  input  logic        config_done,
  input  logic        capture_en,
  output logic [15:0] data_saaSRAM,
  output logic [19:0] addr_saaSRAM,
  output logic        ce_saaSRAM,
  output logic        oe_saaSRAM,
  output logic        we_saaSRAM,
  output logic        field,
  output logic [8:0]  line_cnt,
  output logic        frame_done,
  output logic        error
);

  logic [7:0]  qd_r;
  cap_state_e  state_reg;
  logic        started_reg;
  logic [10:0] pix_reg;
  logic [7:0]  c_reg;
  logic [19:0] wr_addr;

  logic is_ff, is_zero, xy_f, xy_v, xy_h, prot_err;

  bt656_timing_decoder u_dec (
    .qd       (qd_r),
    .is_ff    (is_ff),
    .is_zero  (is_zero),
    .f        (xy_f),
    .v        (xy_v),
    .h        (xy_h),
    .prot_err (prot_err)
  );

  assign wr_addr = (field ? FIELD_STRIDE : 20'd0)
                 + 20'(line_cnt) * 20'(LINE_WORDS)
                 + 20'(pix_reg[10:1]);

  assign oe_saaSRAM = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      qd_r         <= '0;
      state_reg    <= IDLE;
      started_reg  <= 1'b0;
      pix_reg      <= '0;
      c_reg        <= '0;
      data_saaSRAM <= '0;
      addr_saaSRAM <= '0;
      ce_saaSRAM   <= 1'b1;
      we_saaSRAM   <= 1'b1;
      field        <= 1'b0;
      line_cnt     <= '0;
      frame_done   <= 1'b0;
      error        <= 1'b0;
    end else begin
      qd_r       <= qd_in;
      // Strobes and the frame pulse are single-cycle unless a branch below re-asserts them.
      ce_saaSRAM <= 1'b1;
      we_saaSRAM <= 1'b1;
      frame_done <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (config_done && capture_en) begin
            state_reg   <= WAIT_FF;
            started_reg <= 1'b0;
          end
        end

        WAIT_FF: begin
          if (is_ff) state_reg <= ESC1;
        end

        ESC1: begin
          if (is_zero) begin
            state_reg <= ESC2;
          end else begin
            state_reg <= ERROR;
            error     <= 1'b1;
          end
        end

        ESC2: begin
          if (is_zero) begin
            state_reg <= XY;
          end else begin
            state_reg <= ERROR;
            error     <= 1'b1;
          end
        end

        XY: begin
          state_reg <= WAIT_FF;
          if (prot_err) begin
            state_reg <= ERROR;
            error     <= 1'b1;
          end else if (!xy_h) begin
            // SAV: a frame only begins on a field-0 active line; field-1 lines seen first are skipped.
            if (!xy_v && (started_reg || !xy_f)) begin
              state_reg <= ACTIVE;
              pix_reg   <= '0;
              if (!started_reg) begin
                started_reg <= 1'b1;
                field       <= 1'b0;
                line_cnt    <= '0;
              end
            end
          end else if (started_reg) begin
            if (!field && xy_f) begin
              field    <= 1'b1;
              line_cnt <= '0;
            end else if (field && !xy_f) begin
              frame_done <= 1'b1;
              state_reg  <= IDLE;
              field      <= 1'b0;
              line_cnt   <= '0;
            end else if (!xy_v && line_cnt != 9'h1FF) begin
              line_cnt <= line_cnt + 9'd1;
            end
          end
        end

        ACTIVE: begin
          if (is_ff) begin
            state_reg <= ESC1;
          end else if (pix_reg < 11'(LINE_BYTES)) begin
            pix_reg <= pix_reg + 11'd1;
            if (!pix_reg[0]) begin
              c_reg <= qd_r;
            end else if (line_cnt < 9'(MAX_LINES)) begin
              data_saaSRAM <= {qd_r, c_reg};
              addr_saaSRAM <= wr_addr;
              ce_saaSRAM   <= 1'b0;
              we_saaSRAM   <= 1'b0;
            end
          end
        end

        ERROR: begin
          error <= 1'b1;
          if (config_done) state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
